// File: rtl/uart_instruction_rx.sv
// UART 8N1 receiver that packs four bytes (MSB lane first) into a 32-bit instruction,
// with stop-bit framing error strobe and idle timeout that drops partial words.
module uart_instruction_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int TIMEOUT_CLKS = 12000
) (
  input  logic        clk12,
  input  logic        rstn,
  input  logic        rx,
  output logic [31:0] instruction,
  output logic        instruction_rcv,
  output logic        frame_error,
  output logic        rx_busy
);

  localparam int CNT_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic                r_rx_meta;
  logic                r_rx_s;
  logic                r_rx_prev;
  logic [1:0]          r_sync_valid;
  logic                r_armed;
  logic                w_fall;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_n;
  logic [2:0]          r_bit;
  logic [2:0]          w_bit_n;
  logic [7:0]          r_shift;
  logic [7:0]          w_shift_n;
  logic [1:0]          r_byte_cnt;
  logic [1:0]          w_byte_cnt_n;
  logic [23:0]         r_shadow;
  logic [23:0]         w_shadow_n;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic [IDLE_W-1:0]   w_idle_cnt_n;
  logic [31:0]         w_instr_n;
  logic                w_rcv_n;
  logic                w_fe_n;

  // A line held low across reset release must not look like a start edge, so edge
  // detection is armed only once the synchroniser has carried a genuine high sample.
  assign w_fall = r_armed && r_rx_prev && !r_rx_s;

  // Synchroniser, edge history and start-edge arming.
  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      r_rx_meta    <= 1'b1;
      r_rx_s       <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_sync_valid <= 2'b00;
      r_armed      <= 1'b0;
    end else begin
      r_rx_meta    <= rx;
      r_rx_s       <= r_rx_meta;
      r_rx_prev    <= r_rx_s;
      r_sync_valid <= {r_sync_valid[0], 1'b1};
      if (r_sync_valid[1] && r_rx_s) begin
        r_armed <= 1'b1;
      end else begin
        r_armed <= r_armed;
      end
    end
  end

  // Receive FSM next-state, word assembly and timeout.
  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_bit_n      = r_bit;
    w_shift_n    = r_shift;
    w_byte_cnt_n = r_byte_cnt;
    w_shadow_n   = r_shadow;
    w_idle_cnt_n = r_idle_cnt;
    w_instr_n    = instruction;
    w_rcv_n      = 1'b0;
    w_fe_n       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_n = S_START;
          w_cnt_n   = HALF_LOAD;
        end else if (r_byte_cnt != 2'd0) begin
          if (r_idle_cnt == IDLE_LAST) begin
            w_byte_cnt_n = 2'd0;
            w_idle_cnt_n = '0;
          end else begin
            w_idle_cnt_n = r_idle_cnt + 1'b1;
          end
        end else begin
          w_idle_cnt_n = '0;
        end
      end
      S_START: begin
        if (r_cnt == '0) begin
          if (!r_rx_s) begin
            w_state_n = S_DATA;
            w_cnt_n   = BIT_LOAD;
            w_bit_n   = 3'd0;
          end else begin
            w_state_n = S_IDLE;
          end
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_shift_n = {r_rx_s, r_shift[7:1]};
          w_cnt_n   = BIT_LOAD;
          if (r_bit == 3'd7) begin
            w_state_n = S_STOP;
          end else begin
            w_bit_n = r_bit + 3'd1;
          end
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == '0) begin
          w_state_n    = S_IDLE;
          w_idle_cnt_n = '0;
          if (r_rx_s) begin
            case (r_byte_cnt)
              2'd0:    w_shadow_n[23:16] = r_shift;
              2'd1:    w_shadow_n[15:8]  = r_shift;
              2'd2:    w_shadow_n[7:0]   = r_shift;
              default: begin
                w_instr_n = {r_shadow, r_shift};
                w_rcv_n   = 1'b1;
              end
            endcase
            w_byte_cnt_n = r_byte_cnt + 2'd1;
          end else begin
            w_fe_n       = 1'b1;
            w_byte_cnt_n = 2'd0;
          end
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_bit           <= 3'd0;
      r_shift         <= 8'h00;
      r_byte_cnt      <= 2'd0;
      r_shadow        <= 24'h000000;
      r_idle_cnt      <= '0;
      instruction     <= 32'h00000000;
      instruction_rcv <= 1'b0;
      frame_error     <= 1'b0;
      rx_busy         <= 1'b0;
    end else begin
      r_state         <= w_state_n;
      r_cnt           <= w_cnt_n;
      r_bit           <= w_bit_n;
      r_shift         <= w_shift_n;
      r_byte_cnt      <= w_byte_cnt_n;
      r_shadow        <= w_shadow_n;
      r_idle_cnt      <= w_idle_cnt_n;
      instruction     <= w_instr_n;
      instruction_rcv <= w_rcv_n;
      frame_error     <= w_fe_n;
      rx_busy         <= (w_state_n != S_IDLE) || (w_byte_cnt_n != 2'd0);
    end
  end

endmodule

// File: tb/tb_uart_instruction_rx.sv
// Directed bench for uart_instruction_rx: words, glitch, framing error, timeout, mid-frame reset.
module tb_uart_instruction_rx;

  localparam int CPB = 104;
  localparam int TO  = 12000;

  logic        clk12;
  logic        rstn;
  logic        rx;
  logic [31:0] instruction;
  logic        instruction_rcv;
  logic        frame_error;
  logic        rx_busy;

  int checks;
  int errors;
  int cyc;
  int rcv_cnt;
  int fe_cnt;
  int both_cnt;
  int last_rcv_cyc;
  int fall_cyc;
  int base_rcv;
  int base_fe;

  uart_instruction_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk12(clk12),
    .rstn(rstn),
    .rx(rx),
    .instruction(instruction),
    .instruction_rcv(instruction_rcv),
    .frame_error(frame_error),
    .rx_busy(rx_busy)
  );

  initial clk12 = 1'b0;
  always #5 clk12 = ~clk12;

  always @(posedge clk12) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk12) begin
    if (rstn) begin
      if (instruction_rcv) begin
        rcv_cnt      <= rcv_cnt + 1;
        last_rcv_cyc <= cyc;
      end
      if (frame_error) fe_cnt <= fe_cnt + 1;
      if (instruction_rcv && frame_error) both_cnt <= both_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic hold_bits(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk12);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (CPB) @(posedge clk12);
    #1;
    for (int i = 0; i < 8; i++) hold_bits(d[i], CPB);
    hold_bits(stop, CPB);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[15:8], 1'b1);
    send_byte(w[7:0], 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    checks = 0; errors = 0; cyc = 0;
    rcv_cnt = 0; fe_cnt = 0; both_cnt = 0; last_rcv_cyc = 0;
    rx = 1'b1;
    rstn = 1'b0;
    repeat (5) @(posedge clk12);
    #1;
    rstn = 1'b1;
    repeat (10) @(posedge clk12);
    #1;
    check("reset_instruction", instruction, 32'h00000000);
    check("reset_rcv", {31'd0, instruction_rcv}, 32'd0);
    check("reset_fe", {31'd0, frame_error}, 32'd0);
    check("reset_busy", {31'd0, rx_busy}, 32'd0);

    // 0x13000000, with strobe timing on the last byte
    base_rcv = rcv_cnt;
    send_byte(8'h13, 1'b1);
    check("busy_partial", {31'd0, rx_busy}, 32'd1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    hold_bits(1'b1, 20);
    check("w1_instruction", instruction, 32'h13000000);
    check("w1_rcv_count", rcv_cnt - base_rcv, 32'd1);
    check("w1_rcv_timing", last_rcv_cyc - fall_cyc, 32'd991);
    check("w1_no_fe", fe_cnt, 32'd0);
    check("w1_busy_idle", {31'd0, rx_busy}, 32'd0);

    // Two back-to-back words
    base_rcv = rcv_cnt;
    send_word(32'hDEADBEEF);
    check("w2_instruction", instruction, 32'hDEADBEEF);
    send_word(32'h01020304);
    check("w3_instruction", instruction, 32'h01020304);
    check("w23_rcv_count", rcv_cnt - base_rcv, 32'd2);

    // 30-cycle glitch
    base_rcv = rcv_cnt;
    hold_bits(1'b0, 30);
    hold_bits(1'b1, 100);
    check("glitch_no_rcv", rcv_cnt - base_rcv, 32'd0);
    check("glitch_busy", {31'd0, rx_busy}, 32'd0);
    check("glitch_no_fe", fe_cnt, 32'd0);
    send_word(32'h11223344);
    check("w4_instruction", instruction, 32'h11223344);
    check("w4_rcv_count", rcv_cnt - base_rcv, 32'd1);

    // Framing error then a clean word
    base_rcv = rcv_cnt;
    base_fe  = fe_cnt;
    send_byte(8'hAA, 1'b0);
    hold_bits(1'b1, 200);
    check("fe_count", fe_cnt - base_fe, 32'd1);
    check("fe_no_rcv", rcv_cnt - base_rcv, 32'd0);
    check("fe_busy", {31'd0, rx_busy}, 32'd0);
    send_word(32'hCAFEBABE);
    check("w5_instruction", instruction, 32'hCAFEBABE);
    check("w5_rcv_count", rcv_cnt - base_rcv, 32'd1);

    // Timeout discards 0x55 0x66
    base_rcv = rcv_cnt;
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    check("to_busy_before", {31'd0, rx_busy}, 32'd1);
    hold_bits(1'b1, TO + 10);
    check("to_busy_after", {31'd0, rx_busy}, 32'd0);
    send_word(32'h01020304);
    hold_bits(1'b1, 20);
    check("w6_instruction", instruction, 32'h01020304);
    check("w6_rcv_count", rcv_cnt - base_rcv, 32'd1);
    check("w6_busy", {31'd0, rx_busy}, 32'd0);

    // Reset during the 5th data bit of byte 2
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    b = 8'h99;
    hold_bits(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold_bits(b[i], CPB);
    hold_bits(b[4], CPB / 2);
    rstn = 1'b0;
    #1;
    check("rst_instruction", instruction, 32'h00000000);
    check("rst_rcv", {31'd0, instruction_rcv}, 32'd0);
    check("rst_fe", {31'd0, frame_error}, 32'd0);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    rx = 1'b1;
    repeat (5) @(posedge clk12);
    #1;
    rstn = 1'b1;
    hold_bits(1'b1, 50);
    check("post_rst_busy", {31'd0, rx_busy}, 32'd0);
    base_rcv = rcv_cnt;
    send_word(32'h00000013);
    hold_bits(1'b1, 20);
    check("w7_instruction", instruction, 32'h00000013);
    check("w7_rcv_count", rcv_cnt - base_rcv, 32'd1);
    check("never_both", both_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
